// File: rtl/slot_alloc.sv
// slot_alloc: hands out unique slot indices from a DEPTH-entry pool and recycles freed slots in FIFO order.
module slot_alloc #(
    parameter int DEPTH        = 1024,
    parameter int AFULL_THRESH = DEPTH - 4,
    parameter int AW           = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          alloc_req,
    output logic          alloc_rdy,
    output logic          alloc_gnt,
    output logic [AW-1:0] alloc_addr,
    input  logic          free_vld,
    input  logic [AW-1:0] free_addr,
    output logic [AW:0]   used_cnt,
    output logic [AW:0]   peak_cnt,
    output logic          full,
    output logic          almost_full,
    output logic          err,
    output logic [AW-1:0] err_addr,
    input  logic          err_clr
);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AFULL_W = (AW+1)'(AFULL_THRESH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    logic [DEPTH-1:0] bitmap_q, bitmap_d;
    logic [AW:0]      init_idx_q, init_idx_d, q_cnt_q, q_cnt_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]      used_cnt_q, used_cnt_d, peak_cnt_q, peak_cnt_d;
    logic             full_q, full_d, afull_q, afull_d, err_q, err_d;
    logic [AW-1:0]    err_addr_q, err_addr_d;
    logic [AW-1:0]    mem_q [DEPTH];
    logic             init_phase, addr_ok, legal, illegal, pop;

    assign init_phase  = init_idx_q < DEPTH_W;
    assign alloc_rdy   = !flush && (init_phase || q_cnt_q != '0);
    assign alloc_gnt   = alloc_req && alloc_rdy;
    assign alloc_addr  = init_phase ? init_idx_q[AW-1:0] : mem_q[rd_ptr_q];
    // Legality is judged on pre-edge occupancy, so freeing the slot being granted is illegal.
    assign addr_ok     = {1'b0, free_addr} < DEPTH_W;
    assign legal       = !flush && free_vld && addr_ok && bitmap_q[free_addr];
    assign illegal     = !flush && free_vld && !(addr_ok && bitmap_q[free_addr]);
    assign pop         = alloc_gnt && !init_phase;
    assign used_cnt    = used_cnt_q;
    assign peak_cnt    = peak_cnt_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;

    always_comb begin
        bitmap_d = bitmap_q;
        if (alloc_gnt) bitmap_d[alloc_addr] = 1'b1;
        if (legal) bitmap_d[free_addr] = 1'b0;
        if (flush) bitmap_d = '0;
        init_idx_d = flush ? '0 : init_idx_q + (AW+1)'(alloc_gnt && init_phase);
        rd_ptr_d   = flush ? '0 : pop ? nxt(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d   = flush ? '0 : legal ? nxt(wr_ptr_q) : wr_ptr_q;
        q_cnt_d    = flush ? '0 : q_cnt_q + (AW+1)'(legal) - (AW+1)'(pop);
        used_cnt_d = flush ? '0 : used_cnt_q + (AW+1)'(alloc_gnt) - (AW+1)'(legal);
        peak_cnt_d = (flush || err_clr) ? '0 : (used_cnt_d > peak_cnt_q) ? used_cnt_d : peak_cnt_q;
        full_d     = used_cnt_d == DEPTH_W;
        afull_d    = used_cnt_d >= AFULL_W;
        err_d      = illegal || (err_q && !err_clr);
        err_addr_d = (illegal && (!err_q || err_clr)) ? free_addr : err_clr ? '0 : err_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap_q   <= '0;
            init_idx_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            q_cnt_q    <= '0;
            used_cnt_q <= '0;
            peak_cnt_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            bitmap_q   <= bitmap_d;
            init_idx_q <= init_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            q_cnt_q    <= q_cnt_d;
            used_cnt_q <= used_cnt_d;
            peak_cnt_q <= peak_cnt_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (legal) mem_q[wr_ptr_q] <= free_addr;
    end
endmodule
